// File: rtl/fifo_rd_sched.sv
// rtl/fifo_rd_sched.sv - read-side scheduler: FIFO pop, skid buffer, rotating distribution
module fifo_rd_sched #(
  parameter int WIDTH      = 32,
  parameter int NUM_DEST   = 4,
  parameter int SKID_DEPTH = 4
) (
  input  logic                rclk,
  input  logic                rst_n,
  input  logic                fifo_rempty,
  input  logic [WIDTH-1:0]    fifo_rdata,
  output logic                fifo_rinc,
  input  logic [NUM_DEST-1:0] dest_en,
  output logic [WIDTH-1:0]    out_data,
  output logic [NUM_DEST-1:0] out_valid,
  input  logic [NUM_DEST-1:0] out_ready,
  output logic [15:0]         sent_cnt,
  output logic                busy
);
  localparam int PW = (NUM_DEST > 1) ? $clog2(NUM_DEST) : 1;
  localparam int AW = (SKID_DEPTH > 1) ? $clog2(SKID_DEPTH) : 1;
  localparam int CW = $clog2(SKID_DEPTH + 1);
  localparam int OW = CW + 1;

  logic [WIDTH-1:0] mem [SKID_DEPTH];
  logic [AW-1:0]    head;
  logic [AW-1:0]    tail;
  logic [CW-1:0]    cnt;
  logic             v1;
  logic             v2;
  logic [PW-1:0]    ptr;
  logic [PW-1:0]    ptr_next_en;
  logic [OW-1:0]    occ;
  logic             xfer;

  // In-flight words reserve buffer space; a same-cycle drain is deliberately not credited.
  assign occ       = OW'(cnt) + OW'(v1) + OW'(v2);
  assign fifo_rinc = !fifo_rempty && (|dest_en) && (occ < OW'(SKID_DEPTH));
  assign out_data  = mem[head];
  assign busy      = (cnt != '0) || v1 || v2 || fifo_rinc;
  assign xfer      = |(out_valid & out_ready);

  always_comb begin
    out_valid = '0;
    if ((cnt != '0) && dest_en[ptr]) out_valid[ptr] = 1'b1;
  end

  // Nearest enabled index after ptr, cyclically; ptr itself when no other is enabled.
  always_comb begin
    ptr_next_en = ptr;
    for (int k = NUM_DEST - 1; k >= 1; k--) begin
      if (dest_en[PW'((int'(ptr) + k) % NUM_DEST)])
        ptr_next_en = PW'((int'(ptr) + k) % NUM_DEST);
    end
  end

  always_ff @(posedge rclk or negedge rst_n) begin
    if (!rst_n) begin
      head     <= '0;
      tail     <= '0;
      cnt      <= '0;
      v1       <= 1'b0;
      v2       <= 1'b0;
      ptr      <= '0;
      sent_cnt <= '0;
      for (int i = 0; i < SKID_DEPTH; i++) mem[i] <= '0;
    end else begin
      v1 <= fifo_rinc;
      v2 <= v1;
      if (v2) begin
        mem[tail] <= fifo_rdata;
        tail      <= (tail == AW'(SKID_DEPTH - 1)) ? '0 : tail + 1'b1;
      end
      if (xfer) begin
        head     <= (head == AW'(SKID_DEPTH - 1)) ? '0 : head + 1'b1;
        sent_cnt <= sent_cnt + 16'd1;
      end
      case ({v2, xfer})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
      if (xfer || !dest_en[ptr]) ptr <= ptr_next_en;
    end
  end
endmodule

// File: tb/tb_fifo_rd_sched.sv
// tb/tb_fifo_rd_sched.sv - randomized scoreboard bench for fifo_rd_sched
module tb_fifo_rd_sched;
  localparam int WIDTH = 32;
  localparam int ND    = 4;
  localparam int SD    = 4;

  logic             rclk = 1'b0;
  logic             rst_n = 1'b0;
  logic             fifo_rempty = 1'b1;
  logic [WIDTH-1:0] fifo_rdata = '0;
  logic             fifo_rinc;
  logic [ND-1:0]    dest_en = '1;
  logic [WIDTH-1:0] out_data;
  logic [ND-1:0]    out_valid;
  logic [ND-1:0]    out_ready = '0;
  logic [15:0]      sent_cnt;
  logic             busy;

  int checks = 0;
  int errors = 0;

  logic [WIDTH-1:0] fifo_q[$];  // source FIFO contents (not yet popped)
  logic [WIDTH-1:0] wr_q[$];    // written, not yet delivered, in write order
  int               pop_q[$];   // pop cycle of each popped-but-undelivered word
  logic [ND-1:0]    xlog[$];    // observed one-hot of each transfer
  int               tcyc[$];    // cycle of each transfer
  logic [WIDTH-1:0] d1 = '0;
  logic [WIDTH-1:0] d2 = '0;
  bit               force_empty = 1'b0;
  int               cyc = 0;
  logic [1:0]       ptr_m = '0;
  logic [15:0]      sent_m = '0;

  always #5 rclk = ~rclk;

  fifo_rd_sched #(.WIDTH(WIDTH), .NUM_DEST(ND), .SKID_DEPTH(SD)) dut (
    .rclk        (rclk),
    .rst_n       (rst_n),
    .fifo_rempty (fifo_rempty),
    .fifo_rdata  (fifo_rdata),
    .fifo_rinc   (fifo_rinc),
    .dest_en     (dest_en),
    .out_data    (out_data),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .sent_cnt    (sent_cnt),
    .busy        (busy)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [1:0] next_en(input logic [1:0] p, input logic [ND-1:0] m);
    for (int k = 1; k < ND; k++) begin
      if (m[2'((int'(p) + k) % ND)]) return 2'((int'(p) + k) % ND);
    end
    return p;
  endfunction

  task automatic write(input logic [WIDTH-1:0] w);
    fifo_q.push_back(w);
    wr_q.push_back(w);
  endtask

  // One clock: check outputs at negedge against the model, then advance model and source FIFO.
  task automatic tick();
    logic [ND-1:0] ev;
    logic [ND-1:0] en_s;
    logic          er;
    logic          xfer;
    logic          rinc_obs;
    logic          emp;
    logic          head_rdy;
    fifo_rempty = (fifo_q.size() == 0) || force_empty;
    fifo_rdata  = d2;
    @(negedge rclk);
    head_rdy = 1'b0;
    if (pop_q.size() > 0) head_rdy = (pop_q[0] + 3 <= cyc);
    ev = (head_rdy && dest_en[ptr_m]) ? (ND'(1) << ptr_m) : '0;
    er = !fifo_rempty && (|dest_en) && (pop_q.size() < SD);
    chk("out_valid", 64'(out_valid), 64'(ev));
    if (ev != '0) chk("out_data", 64'(out_data), 64'(wr_q[0]));
    chk("fifo_rinc", 64'(fifo_rinc), 64'(er));
    chk("busy", 64'(busy), 64'((pop_q.size() != 0) || er));
    chk("sent_cnt", 64'(sent_cnt), 64'(sent_m));
    if ((out_valid & out_ready) != '0) begin
      xlog.push_back(out_valid & out_ready);
      tcyc.push_back(cyc);
    end
    xfer     = |(ev & out_ready);
    rinc_obs = fifo_rinc;
    emp      = fifo_rempty;
    en_s     = dest_en;
    @(posedge rclk);
    #1;
    d2 = d1;
    if (rinc_obs === 1'b1 && !emp && fifo_q.size() > 0) begin
      d1 = fifo_q.pop_front();
      pop_q.push_back(cyc);
    end
    if (xfer) begin
      void'(pop_q.pop_front());
      void'(wr_q.pop_front());
      sent_m++;
      ptr_m = next_en(ptr_m, en_s);
    end else if (!en_s[ptr_m]) begin
      ptr_m = next_en(ptr_m, en_s);
    end
    cyc++;
  endtask

  task automatic drain(input int max);
    int n = 0;
    while (wr_q.size() != 0 && n < max) begin
      tick();
      n++;
    end
    chk("drain_idle", 64'(wr_q.size()), 64'(0));
    tick();
  endtask

  initial begin
    repeat (2) tick();
    chk("rst_valid", 64'(out_valid), 64'(0));
    chk("rst_data", 64'(out_data), 64'(0));
    rst_n = 1'b1;
    tick();

    // single word
    out_ready = '1;
    write(32'hA5A5_0001);
    xlog.delete();
    drain(30);
    chk("single_sent", 64'(sent_cnt), 64'(1));
    chk("single_dest", 64'(xlog.size() > 0 ? xlog[0] : 4'h0), 64'(4'b0001));
    chk("single_busy", 64'(busy), 64'(0));

    // burst of 8, back to back
    xlog.delete();
    tcyc.delete();
    for (int i = 0; i < 8; i++) write(32'h10 + 32'(i));
    drain(40);
    chk("burst_cnt", 64'(xlog.size()), 64'(8));
    for (int i = 0; i < xlog.size(); i++) chk("burst_dest", 64'(xlog[i]), 64'(ND'(1) << ((1 + i) % ND)));
    for (int i = 1; i < tcyc.size(); i++) chk("burst_b2b", 64'(tcyc[i] - tcyc[i-1]), 64'(1));
    chk("burst_sent", 64'(sent_cnt), 64'(9));

    // backpressure
    out_ready = '0;
    for (int i = 0; i < 10; i++) write(32'h100 + 32'(i));
    repeat (12) tick();
    chk("bp_pops", 64'(10 - fifo_q.size()), 64'(SD));
    out_ready = '1;
    drain(80);

    // mask skip
    dest_en = 4'b0101;
    xlog.delete();
    for (int i = 0; i < 6; i++) write(32'h200 + 32'(i));
    drain(60);
    chk("mask_cnt", 64'(xlog.size()), 64'(6));
    for (int i = 0; i < xlog.size(); i++) chk("mask_dest", 64'(xlog[i]), 64'((i % 2 == 0) ? 4'b0001 : 4'b0100));
    for (int i = 0; i < 8; i++) write(32'h300 + 32'(i));
    repeat (5) tick();
    dest_en = '0;
    repeat (5) tick();
    chk("mask_zero_valid", 64'(out_valid), 64'(0));
    chk("mask_zero_rinc", 64'(fifo_rinc), 64'(0));
    dest_en = 4'b0101;
    drain(60);

    // random: rempty toggling, random ready and mask
    dest_en = '1;
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 2) == 0) write($urandom);
      force_empty = ~force_empty;
      out_ready   = 4'($urandom);
      if (i % 16 == 0) dest_en = 4'($urandom);
      tick();
    end
    force_empty = 1'b0;
    out_ready   = '1;
    dest_en     = '1;
    drain(1500);

    // reset mid-burst
    out_ready = '0;
    for (int i = 0; i < 5; i++) write(32'h400 + 32'(i));
    repeat (7) tick();
    rst_n = 1'b0;
    fifo_q.delete();
    fifo_rempty = 1'b1;
    #1;
    chk("arst_valid", 64'(out_valid), 64'(0));
    chk("arst_data", 64'(out_data), 64'(0));
    chk("arst_sent", 64'(sent_cnt), 64'(0));
    chk("arst_busy", 64'(busy), 64'(0));
    chk("arst_rinc", 64'(fifo_rinc), 64'(0));
    wr_q.delete();
    pop_q.delete();
    d1 = '0;
    d2 = '0;
    ptr_m  = '0;
    sent_m = '0;
    repeat (2) tick();
    rst_n = 1'b1;
    tick();
    xlog.delete();
    out_ready = '1;
    for (int i = 0; i < 3; i++) write(32'h500 + 32'(i));
    drain(40);
    chk("post_rst_dest", 64'(xlog.size() > 0 ? xlog[0] : 4'h0), 64'(4'b0001));
    chk("post_rst_sent", 64'(sent_cnt), 64'(3));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
